// File: rtl/genesys_loop_pkg.sv
// genesys_loop_pkg
//   Shared types and default widths for the loop configuration issuer.
//   - issuer_state_t : issuer FSM states
//   - loop_inst_t    : one buffered loop instruction {iter, group_id, last}
//                      at the default widths
//   - DEF_*          : default parameter values for loop_cfg_issuer
package genesys_loop_pkg;

    localparam int DEF_LOOP_ID_W   = 5;
    localparam int DEF_GROUP_ID_W  = 2;
    localparam int DEF_LOOP_ITER_W = 16;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_START,
        ST_RUN,
        ST_RETIRE
    } issuer_state_t;

    typedef struct packed {
        logic [DEF_LOOP_ITER_W-1:0] iter;
        logic [DEF_GROUP_ID_W-1:0]  group_id;
        logic                       last;
    } loop_inst_t;

endpackage

// File: rtl/loop_cfg_fifo.sv
// loop_cfg_fifo
//   Synchronous first-word-fall-through FIFO holding loop instructions.
//   Ports:
//     clk, reset  : clock, synchronous active-low reset (empties the FIFO)
//     push, wdata : write request / data (ignored while full)
//     pop         : read request (ignored while empty)
//     rdata       : head entry, valid whenever !empty
//     empty, full : occupancy flags for the current cycle
//     full_nxt    : occupancy flag the FIFO will have after this edge
//   DEPTH must be a power of two, at least 2.
module loop_cfg_fifo #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic              full_nxt
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    assign full_nxt = (count_nxt == FULL_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: only entries behind wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/loop_cfg_issuer.sv
// loop_cfg_issuer
//   Buffers loop instructions, issues one config strobe per instruction with
//   a per-group loop index, then starts the block on the controller, waits
//   for its completion and retires it.
//   Ports:
//     clk, reset            : clock, synchronous active-low reset
//     inst_v/inst_ready     : instruction handshake; inst_iter, inst_group_id,
//                             inst_last carry the instruction
//     cfg_loop_iter_v       : one-cycle config strobe with cfg_loop_iter,
//                             cfg_loop_iter_loop_id, cfg_loop_group_id
//     start                 : two-cycle block start pulse
//     done                  : completion pulse (honoured only in RUN)
//     block_done            : one-cycle block retire pulse
//     busy                  : FSM not idle
//     err_overflow          : sticky, an instruction was dropped because its
//                             group ran out of loop indices
//     err_timeout           : sticky, RUN watchdog expired
//   Build option: define LOOP_CFG_ISSUER_TIMEOUT_EN to enable the RUN watchdog
//   (TIMEOUT_CYC cycles); otherwise RUN waits for done forever.
module loop_cfg_issuer
    import genesys_loop_pkg::*;
#(
    parameter int LOOP_ID_W   = DEF_LOOP_ID_W,
    parameter int GROUP_ID_W  = DEF_GROUP_ID_W,
    parameter int LOOP_ITER_W = DEF_LOOP_ITER_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inst_v,
    output logic                   inst_ready,
    input  logic [LOOP_ITER_W-1:0] inst_iter,
    input  logic [GROUP_ID_W-1:0]  inst_group_id,
    input  logic                   inst_last,
    output logic                   cfg_loop_iter_v,
    output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
    output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
    output logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
    output logic                   start,
    input  logic                   done,
    output logic                   block_done,
    output logic                   busy,
    output logic                   err_overflow,
    output logic                   err_timeout
);

    localparam int                 NUM_GROUPS  = 1 << GROUP_ID_W;
    localparam int                 ENTRY_W     = LOOP_ITER_W + GROUP_ID_W + 1;
    // A group is exhausted once its count reaches 2^LOOP_ID_W.
    localparam logic [LOOP_ID_W:0] GRP_CNT_MAX = {1'b1, {LOOP_ID_W{1'b0}}};
    localparam logic [1:0]         START_LEN   = 2'd2;

    issuer_state_t           state;
    logic [1:0]              start_cnt;
    logic [LOOP_ID_W:0]      grp_cnt [NUM_GROUPS];

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [ENTRY_W-1:0]      fifo_rdata;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_full_nxt;
    logic [LOOP_ITER_W-1:0]  head_iter;
    logic [GROUP_ID_W-1:0]   head_gid;
    logic                    head_last;

    // inst_ready is registered and equals !full, so a push never hits a full FIFO.
    assign fifo_push = inst_v && inst_ready;
    assign fifo_pop  = (state == ST_ISSUE) && !fifo_empty;

    assign head_iter = fifo_rdata[ENTRY_W-1 -: LOOP_ITER_W];
    assign head_gid  = fifo_rdata[GROUP_ID_W:1];
    assign head_last = fifo_rdata[0];

    loop_cfg_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .wdata    ({inst_iter, inst_group_id, inst_last}),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .full_nxt (fifo_full_nxt)
    );

`ifdef LOOP_CFG_ISSUER_TIMEOUT_EN
    logic [31:0] wd_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            start_cnt             <= '0;
            for (int g = 0; g < NUM_GROUPS; g++)
                grp_cnt[g] <= '0;
            inst_ready            <= 1'b0;
            cfg_loop_iter_v       <= 1'b0;
            cfg_loop_iter         <= '0;
            cfg_loop_iter_loop_id <= '0;
            cfg_loop_group_id     <= '0;
            start                 <= 1'b0;
            block_done            <= 1'b0;
            busy                  <= 1'b0;
            err_overflow          <= 1'b0;
`ifdef LOOP_CFG_ISSUER_TIMEOUT_EN
            wd_cnt                <= '0;
            err_timeout           <= 1'b0;
`endif
        end else begin
            inst_ready      <= !fifo_full_nxt;
            cfg_loop_iter_v <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!fifo_empty) begin
                        if (grp_cnt[head_gid] == GRP_CNT_MAX) begin
                            err_overflow <= 1'b1;
                        end else begin
                            cfg_loop_iter_v       <= 1'b1;
                            cfg_loop_iter         <= head_iter;
                            cfg_loop_group_id     <= head_gid;
                            cfg_loop_iter_loop_id <= grp_cnt[head_gid][LOOP_ID_W-1:0];
                            grp_cnt[head_gid]     <= grp_cnt[head_gid] + 1'b1;
                        end
                        if (head_last) begin
                            state     <= ST_START;
                            start_cnt <= '0;
                        end
                    end
                end
                // First START cycle carries the last strobe, so start rises
                // one cycle later and stays high for START_LEN cycles.
                ST_START: begin
                    if (start_cnt == START_LEN) begin
                        start <= 1'b0;
                        state <= ST_RUN;
`ifdef LOOP_CFG_ISSUER_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else begin
                        start     <= 1'b1;
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (done) begin
                        state      <= ST_RETIRE;
                        block_done <= 1'b1;
                    end
`ifdef LOOP_CFG_ISSUER_TIMEOUT_EN
                    else if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_RETIRE;
                        block_done  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
`endif
                end
                ST_RETIRE: begin
                    block_done <= 1'b0;
                    for (int g = 0; g < NUM_GROUPS; g++)
                        grp_cnt[g] <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/loop_cfg_issuer.md
LOOP_CFG_ISSUER -- requirements
Module: loop_cfg_issuer

Interface
REQ-001 SHALL have parameter LOOP_ID_W, default 5, loop-index width.
REQ-002 SHALL have parameter GROUP_ID_W, default 2, group-id width.
REQ-003 SHALL have parameter LOOP_ITER_W, default 16, iteration-bound width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), instruction buffer entries.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, watchdog limit (used only under REQ-029).
REQ-006 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-low reset.
  inst_v  in  1  loop instruction valid.
  inst_ready  out  1  instruction accepted when inst_v && inst_ready.
  inst_iter  in  LOOP_ITER_W  loop bound.
  inst_group_id  in  GROUP_ID_W  target group.
  inst_last  in  1  final entry of block.
  cfg_loop_iter_v  out  1  one-cycle config strobe to controller.
  cfg_loop_iter  out  LOOP_ITER_W  bound.
  cfg_loop_iter_loop_id  out  LOOP_ID_W  per-group loop index.
  cfg_loop_group_id  out  GROUP_ID_W  group.
  start  out  1  block start to controller.
  done  in  1  one-cycle completion pulse from controller.
  block_done  out  1  one-cycle block-retire pulse to controller.
  busy  out  1  state != IDLE.
  err_overflow  out  1  sticky, entry dropped.
  err_timeout  out  1  sticky, watchdog fired.

Function
REQ-007 SHALL buffer instructions {iter, group_id, last} in a FIFO_DEPTH-entry FIFO; inst_ready = !full.
REQ-008 Push on full SHALL NOT occur; simultaneous push and pop when full SHALL be allowed (ready stays low that cycle; the pop frees an entry for the next cycle).
REQ-009 FSM states SHALL be IDLE, ISSUE, START, RUN, RETIRE.
REQ-010 IDLE -> ISSUE when FIFO non-empty.
REQ-011 ISSUE SHALL pop at most one entry per cycle; each non-dropped pop drives cfg_loop_iter_v=1 with fields registered (1-cycle latency from pop).
REQ-012 cfg_loop_iter_loop_id SHALL equal the current per-group count for that group, then the count increments.
REQ-013 An entry whose group count already equals 2^LOOP_ID_W SHALL be dropped (no strobe); err_overflow set.
REQ-014 ISSUE with FIFO empty SHALL wait (no strobe) without leaving ISSUE.
REQ-015 A popped entry with inst_last=1 SHALL move ISSUE -> START after its strobe cycle; a dropped last entry also ends the block.
REQ-016 START SHALL assert start high for exactly 2 cycles (edge-detectable by controller), then -> RUN.
REQ-017 RUN SHALL hold start low and wait for done=1; then -> RETIRE.
REQ-018 done outside RUN SHALL be ignored.
REQ-019 RETIRE SHALL assert block_done for 1 cycle, clear all per-group counts, -> IDLE.
REQ-020 No pops SHALL occur in START, RUN, RETIRE; pushes continue while FIFO not full.
REQ-021 cfg_loop_iter_v, start, block_done SHALL be mutually exclusive in any cycle.
REQ-022 Outputs SHALL be registered.

Reset
REQ-023 reset=0 SHALL, at next clk edge, set state IDLE, FIFO empty, all counts 0.
REQ-024 Reset values: inst_ready=0 during reset, 1 after; cfg_loop_iter_v=0, cfg fields=0, start=0, block_done=0, busy=0, err_overflow=0, err_timeout=0.
REQ-025 Reset mid-block SHALL abandon the block without a block_done pulse.
REQ-026 err_overflow and err_timeout SHALL clear only on reset.

Configuration
REQ-027 Macro LOOP_CFG_ISSUER_TIMEOUT_EN SHALL select the watchdog.
REQ-028 Without it: RUN waits indefinitely; err_timeout tied 0.
REQ-029 With it: a counter cleared on RUN entry increments each RUN cycle; on reaching TIMEOUT_CYC without done, set err_timeout and -> RETIRE (block_done still pulses).

Structure
REQ-030 Package genesys_loop_pkg SHALL hold the FSM state enum, the FIFO entry struct, and default width constants.
REQ-031 FIFO SHALL be sub-module loop_cfg_fifo (sync, first-word-fall-through, full/empty flags).

Verification
REQ-032 Push {10,g0},{20,g0},{5,g1,last} -> strobes loop_id 0,1 g0 then 0 g1, iter 10/20/5; start 2 cycles; done -> block_done 1 cycle.
REQ-033 Push 6 entries back-to-back, depth 4 -> inst_ready low after 4 accepted, no loss, strobes in order.
REQ-034 33 entries to g2 (LOOP_ID_W=5) -> 32 strobes ids 0..31, 33rd dropped, err_overflow=1, block still retires.
REQ-035 done pulsed during ISSUE -> ignored; block_done only after done in RUN.
REQ-036 reset=0 in RUN -> next cycle IDLE, start/block_done 0, FIFO empty, new block issues ids from 0.
REQ-037 TIMEOUT_EN, TIMEOUT_CYC=8, no done -> err_timeout=1 and block_done after 8 RUN cycles; without macro, busy stays 1.
